// File: rtl/md_defs_pkg.sv
// rtl/md_defs_pkg.sv - md-class opcode encodings and scheduler state constants
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } mdOp_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

  function automatic logic isMulDiv(input mdOp_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivide(input mdOp_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational {hi,lo} result for mult/multu/div/divu
// Divide results are {remainder, quotient}; divByZero tells the caller to keep hi/lo.
module md_arith
  import md_defs::*;
(
  input  mdOp_t       op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        divByZero
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic               divOverflow;

  assign sa          = {{32{a[31]}}, a};
  assign sb          = {{32{b[31]}}, b};
  assign divOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    result    = '0;
    divByZero = 1'b0;
    case (op)
      MD_MULT:  result = sa * sb;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) begin
          divByZero = 1'b1;
        end else if (divOverflow) begin
          // The only signed quotient that does not fit: wraps back to the dividend.
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          divByZero = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - E-stage multiply/divide scheduler owning HI/LO
// Optional flush input md_cancel when MD_CANCEL_EN is defined.
module md_unit_ctrl
  import md_defs::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic        e_valid,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
`ifdef MD_CANCEL_EN
  input  logic        md_cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;
  mdOp_t            eOp;
  mdOp_t            pendOp;
  logic [31:0]      opA;
  logic [31:0]      opB;
  logic [63:0]      result;
  logic             divByZero;
  logic             cancel;

`ifdef MD_CANCEL_EN
  assign cancel = md_cancel;
`else
  assign cancel = 1'b0;
`endif

  assign eOp      = mdOp_t'(e_md_op);
  assign start    = e_valid & ~busy & ~cancel & isMulDiv(eOp);
  assign stall_md = d_is_md & (start | busy);
  // No bypass of an in-flight result: the D-stage stall keeps MFHI/MFLO behind it.
  assign md_rdata = (eOp == MD_MFHI) ? hi :
                    (eOp == MD_MFLO) ? lo : 32'd0;

  md_arith u_arith (
    .op        (pendOp),
    .a         (opA),
    .b         (opB),
    .result    (result),
    .divByZero (divByZero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      pendOp <= MD_NONE;
      opA    <= 32'd0;
      opB    <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (cancel) begin
      state <= MD_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_BUSY;
            busy   <= 1'b1;
            cnt    <= isDivide(eOp) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            pendOp <= eOp;
            opA    <= e_rs;
            opB    <= e_rt;
          end else if (e_valid && eOp == MD_MTHI) begin
            hi <= e_rs;
          end else if (e_valid && eOp == MD_MTLO) begin
            lo <= e_rs;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            if (!divByZero) begin
              {hi, lo} <= result;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - randomized bench for md_unit_ctrl with a behavioural HI/LO model
module tb_md_unit_ctrl;
  import md_defs::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  e_md_op = 4'd0;
  logic        e_valid = 1'b0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        d_is_md = 1'b0;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        cancelNow;

`ifdef MD_CANCEL_EN
  logic md_cancel = 1'b0;
  assign cancelNow = md_cancel;
`else
  assign cancelNow = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_md_op  (e_md_op),
    .e_valid  (e_valid),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_is_md  (d_is_md),
`ifdef MD_CANCEL_EN
    .md_cancel(md_cancel),
`endif
    .start    (start),
    .busy     (busy),
    .stall_md (stall_md),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from magnitudes and sign rules; returns {div0, hi, lo}.
  function automatic logic [64:0] refCalc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = 64'd0;
    if (op == MD_MULT) begin
      p = sa * sb;
    end else if (op == MD_MULTU) begin
      ua = a;
      ub = b;
      p  = ua * ub;
    end else if (op == MD_DIV || op == MD_DIVU) begin
      if (b == 32'd0) return {1'b1, 64'd0};
      if (op == MD_DIV) begin
        ua = (sa < 0) ? -sa : sa;
        ub = (sb < 0) ? -sb : sb;
      end else begin
        ua = a;
        ub = b;
      end
      q = ua / ub;
      r = ua % ub;
      if (op == MD_DIV && (a[31] ^ b[31])) q = -q;
      if (op == MD_DIV && a[31]) r = -r;
      p = {r[31:0], q[31:0]};
    end
    return {1'b0, p};
  endfunction

  int          mRemain = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] pHi = 32'd0;
  logic [31:0] pLo = 32'd0;
  logic        pDiv0 = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mRemain <= 0;
      mHi     <= 32'd0;
      mLo     <= 32'd0;
    end else if (cancelNow) begin
      mRemain <= 0;
    end else if (mRemain > 0) begin
      mRemain <= mRemain - 1;
      if (mRemain == 1 && !pDiv0) begin
        mHi <= pHi;
        mLo <= pLo;
      end
    end else if (e_valid) begin
      if (e_md_op >= 4'd1 && e_md_op <= 4'd4) begin
        mRemain <= (e_md_op >= 4'd3) ? DIV_N : MUL_N;
        {pDiv0, pHi, pLo} <= refCalc(e_md_op, e_rs, e_rt);
      end else if (e_md_op == 4'd5) begin
        mHi <= e_rs;
      end else if (e_md_op == 4'd6) begin
        mLo <= e_rs;
      end
    end
  end

  always @(negedge clk) begin
    logic        eb;
    logic        es;
    logic [31:0] er;
    if (cmpEn) begin
      eb = (mRemain > 0);
      es = e_valid && !eb && !cancelNow && (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
      er = (e_md_op == 4'd7) ? mHi : (e_md_op == 4'd8) ? mLo : 32'd0;
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("start", {31'd0, start}, {31'd0, es});
      chk("stall_md", {31'd0, stall_md}, {31'd0, d_is_md && (es || eb)});
      chk("hi", hi, mHi);
      chk("lo", lo, mLo);
      chk("md_rdata", md_rdata, er);
    end
  end

  task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] a, input logic [31:0] b, input logic dm);
    e_md_op = op;
    e_valid = v;
    e_rs    = a;
    e_rt    = b;
    d_is_md = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    drive(op, 1'b1, a, b, 1'b0);
    step();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      atNeg();
      chk("op busy window", {31'd0, busy}, 32'd1);
      step();
    end
    atNeg();
    chk("op busy released", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step();
    step();
    cmpEn = 1'b1;
    atNeg();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;
    step();

    drive(MD_MULT, 1'b1, 32'd3, 32'hFFFF_FFFE, 1'b1);
    atNeg();
    chk("mult start", {31'd0, start}, 32'd1);
    chk("mult stall at start", {31'd0, stall_md}, 32'd1);
    step();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < MUL_N; i++) begin
      atNeg();
      chk("mult busy", {31'd0, busy}, 32'd1);
      chk("mult stall", {31'd0, stall_md}, 32'd1);
      step();
    end
    atNeg();
    chk("mult done busy", {31'd0, busy}, 32'd0);
    chk("mult stall released", {31'd0, stall_md}, 32'd0);
    chk("mult hi", hi, 32'hFFFF_FFFF);
    chk("mult lo", lo, 32'hFFFF_FFFA);
    drive(MD_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
    atNeg();
    chk("mflo after mult", md_rdata, 32'hFFFF_FFFA);
    step();

    runOp(MD_DIVU, 32'd7, 32'd2, DIV_N);
    chk("divu lo", lo, 32'd3);
    chk("divu hi", hi, 32'd1);
    runOp(MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);
    runOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    chk("div ovf lo", lo, 32'h8000_0000);
    chk("div ovf hi", hi, 32'd0);

    drive(MD_MTHI, 1'b1, 32'h11, 32'd0, 1'b0);
    step();
    drive(MD_MTLO, 1'b1, 32'h22, 32'd0, 1'b0);
    step();
    runOp(MD_DIV, 32'd5, 32'd0, DIV_N);
    chk("div0 hi", hi, 32'h11);
    chk("div0 lo", lo, 32'h22);

    drive(MD_MTHI, 1'b1, 32'hDEAD, 32'd0, 1'b0);
    atNeg();
    chk("mthi no busy", {31'd0, busy}, 32'd0);
    step();
    drive(MD_MFHI, 1'b1, 32'd0, 32'd0, 1'b0);
    atNeg();
    chk("mfhi data", md_rdata, 32'hDEAD);
    chk("mfhi no busy", {31'd0, busy}, 32'd0);
    step();

`ifdef MD_CANCEL_EN
    drive(MD_DIV, 1'b1, 32'd100, 32'd7, 1'b0);
    step();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    md_cancel = 1'b1;
    step();
    md_cancel = 1'b0;
    atNeg();
    chk("cancel busy", {31'd0, busy}, 32'd0);
    chk("cancel hi kept", hi, 32'hDEAD);
    step();
`endif

    drive(MD_DIV, 1'b1, 32'd100, 32'd7, 1'b0);
    step();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset hi", hi, 32'd0);
    chk("async reset lo", lo, 32'd0);
    step();
    reset = 1'b1;
    step();

    for (int c = 0; c < 3000; c++) begin
      drive(4'($urandom_range(0, 8)), 1'(($urandom % 4) != 0), pick(), pick(), 1'($urandom % 2));
      reset = 1'(($urandom % 400) != 0);
`ifdef MD_CANCEL_EN
      md_cancel = 1'(($urandom % 40) == 0);
`endif
      step();
    end

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
